// File: rtl/pmsm_v3.sv
// Fixed-point, cycle-stepped PMSM plant: six-step inverter states in, phase
// currents, torque, speed and electrical position out, one time step per clock.
module pmsm_v3 #(
  parameter int          V_STEP   = 1024,
  parameter int          R_GAIN   = 16,
  parameter int          L_SHIFT  = 4,
  parameter int          F_SHIFT  = 6,
  parameter int          J_SHIFT  = 3,
  parameter int          P_SHIFT  = 4,
  parameter logic [15:0] POS_INIT = 16'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         V_phase,
  output logic signed [15:0] I_a,
  output logic signed [15:0] I_b,
  output logic signed [15:0] I_c,
  output logic signed [15:0] torque,
  output logic signed [15:0] speed,
  output logic [15:0]        position
);

  localparam logic signed [33:0] V_STEP_S = 34'(V_STEP);
  localparam logic signed [33:0] R_GAIN_S = 34'(R_GAIN);
  // 120 degrees of electrical angle in position counts
  localparam logic [15:0] PHASE_OFS = 16'd21845;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
    if (x > 34'sd32767) begin
      sat16 = 16'sh7fff;
    end else if (x < -34'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = x[15:0];
    end
  endfunction

  // 32-point sine, Q1.14, built from the first quarter wave plus symmetry
  function automatic logic signed [15:0] sin_rom(input logic [4:0] idx);
    logic [3:0]        q;
    logic signed [15:0] mag;
    q = (idx[3:0] > 4'd8) ? (4'd0 - idx[3:0]) : idx[3:0];
    case (q)
      4'd0:    mag = 16'sd0;
      4'd1:    mag = 16'sd3196;
      4'd2:    mag = 16'sd6270;
      4'd3:    mag = 16'sd9102;
      4'd4:    mag = 16'sd11585;
      4'd5:    mag = 16'sd13623;
      4'd6:    mag = 16'sd15137;
      4'd7:    mag = 16'sd16069;
      4'd8:    mag = 16'sd16384;
      default: mag = 16'sd0;
    endcase
    if (idx[4]) begin
      sin_rom = -mag;
    end else begin
      sin_rom = mag;
    end
  endfunction

  function automatic logic signed [33:0] phase_v(input logic x, input logic y, input logic z);
    logic signed [33:0] k;
    k = $signed({32'd0, x, 1'b0}) - $signed({33'd0, y}) - $signed({33'd0, z});
    phase_v = k * V_STEP_S;
  endfunction

  function automatic logic signed [15:0] cur_next(
    input logic signed [15:0] i_x,
    input logic signed [33:0] v_x,
    input logic signed [15:0] s_x,
    input logic signed [15:0] spd
  );
    logic signed [33:0] e_x;
    logic signed [33:0] r_x;
    logic signed [33:0] d_x;
    e_x = 34'(spd) * 34'(s_x);
    e_x = e_x >>> 14;
    r_x = 34'(i_x) * R_GAIN_S;
    r_x = r_x >>> 4;
    d_x = v_x - e_x - r_x;
    d_x = d_x >>> L_SHIFT;
    cur_next = sat16(34'(i_x) + d_x);
  endfunction

  logic signed [33:0] v_a_s, v_b_s, v_c_s;
  logic signed [15:0] s_a_s, s_b_s, s_c_s;
  logic signed [15:0] i_a_nxt_s, i_b_nxt_s, i_c_nxt_s;
  logic signed [15:0] torque_nxt_s, speed_nxt_s;
  logic [15:0]        position_nxt_s;
  logic signed [33:0] tq_sum_s, spd_d_s;
  logic [15:0]        pos_d_s;

  // Next-state evaluation from the current registered state only
  always_comb begin
    v_a_s = phase_v(V_phase[0], V_phase[1], V_phase[2]);
    v_b_s = phase_v(V_phase[1], V_phase[0], V_phase[2]);
    v_c_s = phase_v(V_phase[2], V_phase[0], V_phase[1]);

    s_a_s = sin_rom(position[15:11]);
    s_b_s = sin_rom(5'((position - PHASE_OFS) >> 11));
    s_c_s = sin_rom(5'((position + PHASE_OFS) >> 11));

    i_a_nxt_s = cur_next(I_a, v_a_s, s_a_s, speed);
    i_b_nxt_s = cur_next(I_b, v_b_s, s_b_s, speed);
    i_c_nxt_s = cur_next(I_c, v_c_s, s_c_s, speed);

    tq_sum_s = 34'(I_a) * 34'(s_a_s) + 34'(I_b) * 34'(s_b_s) + 34'(I_c) * 34'(s_c_s);
    tq_sum_s = tq_sum_s >>> 14;
    torque_nxt_s = sat16(tq_sum_s);

    spd_d_s = 34'(torque) - (34'(speed) >>> F_SHIFT);
    spd_d_s = spd_d_s >>> J_SHIFT;
    speed_nxt_s = sat16(34'(speed) + spd_d_s);

    // position deliberately wraps modulo one electrical revolution
    pos_d_s = 16'(34'(speed) >>> P_SHIFT);
    position_nxt_s = position + pos_d_s;
  end

  // Plant state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      I_a      <= 16'sd0;
      I_b      <= 16'sd0;
      I_c      <= 16'sd0;
      torque   <= 16'sd0;
      speed    <= 16'sd0;
      position <= POS_INIT;
    end else begin
      I_a      <= i_a_nxt_s;
      I_b      <= i_b_nxt_s;
      I_c      <= i_c_nxt_s;
      torque   <= torque_nxt_s;
      speed    <= speed_nxt_s;
      position <= position_nxt_s;
    end
  end

endmodule

// File: tb/tb_pmsm_v3.sv
// Directed self-checking bench for pmsm_v3 with hand-computed expectations
// and per-cycle checks of the speed and position update equations.
module tb_pmsm_v3;

  logic               clk;
  logic               rst_n;
  logic [2:0]         v_phase;
  logic signed [15:0] i_a, i_b, i_c, torque, speed;
  logic [15:0]        position;

  int n_checks;
  int n_errors;

  pmsm_v3 dut (
    .clk(clk), .rst_n(rst_n), .V_phase(v_phase),
    .I_a(i_a), .I_b(i_b), .I_c(i_c),
    .torque(torque), .speed(speed), .position(position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    else if (x < -32768) return -32768;
    else return x;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input int ea, input int eb, input int ec,
                         input int et, input int es, input int ep);
    chk({tag, ".I_a"}, int'(i_a), ea);
    chk({tag, ".I_b"}, int'(i_b), eb);
    chk({tag, ".I_c"}, int'(i_c), ec);
    chk({tag, ".torque"}, int'(torque), et);
    chk({tag, ".speed"}, int'(speed), es);
    chk({tag, ".position"}, int'(position), ep);
  endtask

  // one cycle of the mechanical equations checked against the previous state
  task automatic step_mech(input string tag);
    int ps, pt, pp, es, ep;
    ps = int'(speed);
    pt = int'(torque);
    pp = int'(position);
    step();
    es = clamp16(ps + ((pt - (ps >>> 6)) >>> 3));
    ep = (pp + (ps >>> 4)) & 32'hFFFF;
    chk({tag, ".speed"}, int'(speed), es);
    chk({tag, ".position"}, int'(position), ep);
  endtask

  logic [2:0] codes [6];
  int         exp1  [6][3];
  int         exp2  [6][3];
  logic [2:0] seq   [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    codes = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101};
    exp1  = '{'{128, -64, -64}, '{-64, 128, -64}, '{-64, -64, 128},
              '{64, 64, -128},  '{-128, 64, 64},  '{64, -128, 64}};
    exp2  = '{'{120, -60, -60}, '{-60, 120, -60}, '{-60, -60, 120},
              '{60, 60, -120},  '{-120, 60, 60},  '{60, -120, 60}};
    seq   = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};

    // reset held with a drive applied, then 100 coast cycles
    rst_n   = 1'b0;
    v_phase = 3'b001;
    for (int k = 0; k < 5; k++) step();
    chk_all("in_reset", 0, 0, 0, 0, 0, 0);
    v_phase = 3'b000;
    rst_n   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      chk_all("coast000", 0, 0, 0, 0, 0, 0);
    end

    // first edges from reset with phase A energised
    do_reset();
    v_phase = 3'b001;
    step();
    chk_all("edge1", 128, -64, -64, 0, 0, 0);
    step();
    chk_all("edge2", 248, -124, -124, -6, 0, 0);
    step();
    chk_all("edge3", 360, -181, -181, -12, -1, 0);
    step();
    chk_all("edge4", 465, -234, -234, -17, -3, 65535);

    // asynchronous reset between edges while the rotor is moving
    #1 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("rst_hold", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("resume", 128, -64, -64, 0, 0, 0);

    // every active code for one cycle, then one coast cycle
    for (int n = 0; n < 6; n++) begin
      do_reset();
      v_phase = codes[n];
      step();
      chk("code.I_a", int'(i_a), exp1[n][0]);
      chk("code.I_b", int'(i_b), exp1[n][1]);
      chk("code.I_c", int'(i_c), exp1[n][2]);
      chk("code.sum_ok", int'((int'(i_a) + int'(i_b) + int'(i_c)) inside {[-3:3]}), 1);
      v_phase = 3'b111;
      step();
      chk("decay.I_a", int'(i_a), exp2[n][0]);
      chk("decay.I_b", int'(i_b), exp2[n][1]);
      chk("decay.I_c", int'(i_c), exp2[n][2]);
    end

    // long hold of one vector
    do_reset();
    v_phase = 3'b001;
    for (int k = 0; k < 5000; k++) step_mech("hold001");

    // rotating six-step sequence including a coast slot
    for (int k = 0; k < 3500; k++) begin
      v_phase = seq[(k / 2) % 7];
      step_mech("sixstep");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pmsm_v3.md
# pmsm_v3

Cycle-stepped behavioural model of a three-phase permanent-magnet synchronous motor, in fixed point. Each clock edge advances the motor by one discrete time step. The inputs are six-step inverter switch states; the outputs are phase currents, electromagnetic torque, rotor speed and electrical position. The block sits at the plant side of motor-control test setups, where it stands in for the real motor and inverter in closed-loop simulation and FPGA emulation.

## Interface
- V_STEP, 1024: per-unit phase-voltage step (signed counts).
- R_GAIN, 16: stator resistance, Q4 (16 = 1.0).
- L_SHIFT, 4: inductance, expressed as a right-shift applied to the current derivative.
- F_SHIFT, 6: viscous friction, as a right-shift applied to speed.
- J_SHIFT, 3: inertia, as a right-shift applied to net torque.
- P_SHIFT, 4: speed-to-position integration shift.
- POS_INIT, 0: position value loaded by reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- V_phase  in  3  inverter high-side states: bit0 = A, bit1 = B, bit2 = C.
- I_a, I_b, I_c  out  16  phase currents, signed two's complement.
- torque  out  16  electromagnetic torque, signed.
- speed  out  16  electrical speed, signed.
- position  out  16  electrical angle, unsigned; 65536 counts = 360°.

## Operation
- Phase voltages are combinational from V_phase, with a, b, c in {0,1}:
  - v_a = V_STEP·(2a−b−c)
  - v_b = V_STEP·(2b−a−c)
  - v_c = V_STEP·(2c−a−b)
  - 000 and 111 give zero on all phases (coast).
- Sine factors use a 32-entry ROM, entry k = round(16384·sin(2πk/32)), Q1.14:
  - s_a = ROM[position[15:11]]
  - s_b = ROM[(position−21845)[15:11]]
  - s_c = ROM[(position+21845)[15:11]]
  - Address arithmetic is mod 2^16.
- Per-edge update. All right-hand sides use the current registered values; all registers update simultaneously.
  - e_x = (speed·s_x) >>> 14
  - I_x ← sat16( I_x + ((v_x − e_x − ((I_x·R_GAIN) >>> 4)) >>> L_SHIFT) )
  - torque ← sat16( (I_a·s_a + I_b·s_b + I_c·s_c) >>> 14 )
  - speed ← sat16( speed + ((torque − (speed >>> F_SHIFT)) >>> J_SHIFT) )
  - position ← position + sign-extended (speed >>> P_SHIFT), mod 2^16
- Arithmetic rules:
  - `>>>` is an arithmetic shift (floor toward −∞).
  - Intermediates are at least 34 bits wide, so nothing overflows before saturation.
  - sat16 clamps the result to [−32768, 32767].
- Position never saturates; it wraps in both directions (65535+1 → 0, 0−1 → 65535).
- Reverse rotation results naturally from negative torque; there is no separate direction input.

## Timing
- Reset (rst_n low, asynchronous):
  - I_a, I_b, I_c, torque and speed clear to 0.
  - position loads POS_INIT.
  - Outputs hold these values while rst_n is low.
- The first update happens on the first rising clk edge after rst_n deasserts. Deassertion is assumed synchronous to clk.
- All outputs are registered.
- Latency from a V_phase change:
  - currents: 1 cycle
  - torque: 2 cycles
  - speed: 3 cycles
  - position: 4 cycles
- V_phase is sampled every edge. There is no handshake and no hold requirement beyond setup/hold to clk.
- A reset asserted mid-operation forces reset values immediately, regardless of clk.

## Test plan
- Reset with V_phase = 000, 100 cycles:
  - All outputs stay 0.
  - position stays at POS_INIT.
- Reset with POS_INIT = 0, then V_phase = 001 (defaults):
  - After edge 1: I_a = 128, I_b = I_c = −64, torque = 0.
  - After edge 2: torque = −6 (s_a = 0, s_b = −13623, s_c = 15137).
- Apply each code 001, 010, 100, 011, 110, 101 from reset for 1 cycle:
  - The energized phase(s) move toward +/− as given by the v_x formula.
  - I_a + I_b + I_c stays within ±3.
- Hold V_phase = 001 for 5000 cycles:
  - No output wraps; currents, torque and speed stay within [−32768, 32767].
  - Position changes monotonically in the direction of sign(speed), wrapping through 0.
- Rotate the six-step sequence (testbench order: 001, 010, 100, 011, 110, 101, 111; 2 cycles each) for 3500 cycles:
  - Outputs remain bounded.
  - The 111 step yields zero applied voltage; currents decay toward 0 when speed ≈ 0.
- Assert rst_n low between clock edges while speed ≠ 0:
  - All outputs clear without waiting for a clk edge.
  - Normal stepping resumes on the first edge after release.
